// File: rtl/rv_encode_pkg.sv
// rv_encode_pkg: shared RV32I encoding constants, operation classes,
// immediate formats and loader states.
package rv_encode_pkg;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   typedef enum logic [2:0] {
      OP_LW    = 3'd0,
      OP_SW    = 3'd1,
      OP_RTYPE = 3'd2,
      OP_BEQ   = 3'd3,
      OP_ITYPE = 3'd4,
      OP_JAL   = 3'd5
   } op_t;
   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD} fmt_t;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} ld_state_t;
   function automatic fmt_t op_fmt(input logic [2:0] op);
      return (op == OP_LW || op == OP_ITYPE) ? FMT_I :
             (op == OP_SW)    ? FMT_S :
             (op == OP_RTYPE) ? FMT_R :
             (op == OP_BEQ)   ? FMT_B :
             (op == OP_JAL)   ? FMT_J : FMT_BAD;
   endfunction
   function automatic logic [6:0] op_opcode(input logic [2:0] op);
      return (op == OP_LW)    ? OPC_LOAD :
             (op == OP_SW)    ? OPC_STORE :
             (op == OP_RTYPE) ? OPC_OP :
             (op == OP_BEQ)   ? OPC_BRANCH :
             (op == OP_ITYPE) ? OPC_OP_IMM :
             (op == OP_JAL)   ? OPC_JAL : 7'b0;
   endfunction
endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational packing of decoded fields into one RV32I word.
//   op        operation class (0..5 legal)
//   rd/rs1/rs2 register indices
//   funct3    used by R-type and I-type ALU only
//   funct7b5  used by R-type only
//   imm       signed byte immediate/offset
//   word      encoded instruction
//   illegal   op class illegal or immediate not representable
module instr_field_packer
   import rv_encode_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);
   fmt_t       fmt;
   logic [6:0] opc;
   logic [2:0] f3;
   logic       i_ok, b_ok, j_ok;
   always_comb begin
      fmt = op_fmt(op);
      opc = op_opcode(op);
      f3  = (op == OP_RTYPE || op == OP_ITYPE) ? funct3 : (op == OP_BEQ) ? 3'b000 : 3'b010;
      // representable iff the upper bits are a pure sign extension of the field's top bit
      i_ok = imm[31:11] == {21{imm[11]}};
      b_ok = imm[31:12] == {20{imm[12]}} && !imm[0];
      j_ok = imm[31:20] == {12{imm[20]}} && !imm[0];
      case (fmt)
         FMT_R:   word = {1'b0, funct7b5, 5'b0, rs2, rs1, f3, rd, opc};
         FMT_I:   word = {imm[11:0], rs1, f3, rd, opc};
         FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
         FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
         FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
         default: word = 32'b0;
      endcase
      illegal = (fmt == FMT_BAD) ||
                ((fmt == FMT_I || fmt == FMT_S) && !i_ok) ||
                (fmt == FMT_B && !b_ok) ||
                (fmt == FMT_J && !j_ok);
   end
endmodule

// File: rtl/imem_program_encoder.sv
// imem_program_encoder: encodes field bundles into RV32I words and loads them
// sequentially into instruction memory, holding the core in reset until done.
//   start                one-cycle pulse, restarts a load at BASE_ADDR
//   in_valid/in_ready    bundle handshake, in_last marks the final instruction
//   in_op..in_imm        decoded instruction fields
//   imem_we/addr/wdata   registered memory write port
//   busy/done/err        loading / loaded (sticky) / aborted (sticky)
//   cpu_rst_n            core reset release, high only once loaded
module imem_program_encoder
   import rv_encode_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_rst_n
);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   ld_state_t         state;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       word;
   logic              illegal;
   logic              accept;
   logic              at_top;
   instr_field_packer u_packer (
      .op       (in_op),
      .rd       (in_rd),
      .rs1      (in_rs1),
      .rs2      (in_rs2),
      .funct3   (in_funct3),
      .funct7b5 (in_funct7b5),
      .imm      (in_imm),
      .word     (word),
      .illegal  (illegal)
   );
   assign in_ready  = state == ST_LOAD;
   assign busy      = state == ST_LOAD;
   assign done      = state == ST_DONE;
   assign err       = state == ST_ERR;
   assign cpu_rst_n = state == ST_DONE;
   assign accept    = in_valid && in_ready;
   assign at_top    = &ptr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= BASE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            state <= ST_LOAD;
            ptr   <= BASE;
         end else if (accept) begin
            if (illegal) begin
               state <= ST_ERR;
            end else begin
               imem_we    <= 1'b1;
               imem_addr  <= ptr;
               imem_wdata <= word;
               // the last slot is still written; a further non-last bundle would wrap
               state      <= in_last ? ST_DONE : at_top ? ST_ERR : ST_LOAD;
               ptr        <= at_top ? ptr : ptr + ADDR_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_imem_program_encoder.sv
// tb_imem_program_encoder: randomized and directed checks of two encoder
// instances (64-word and 4-word memories) against a behavioural model.
module tb_imem_program_encoder;
   logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0, in_f7 = 0;
   logic [2:0]  in_op = 0, in_f3 = 0;
   logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
   logic [31:0] in_imm = 0;
   logic        rdy0, we0, busy0, done0, err0, crst0;
   logic        rdy1, we1, busy1, done1, err1, crst1;
   logic [5:0]  addr0;
   logic [1:0]  addr1;
   logic [31:0] wd0, wd1;
   int          cmp = 0, bad = 0;
   int          mst[2] = '{0, 0};
   int          mptr[2] = '{0, 0};
   int          maddr[2] = '{0, 0};
   bit          mwe[2] = '{0, 0};
   logic [31:0] mwd[2] = '{0, 0};
   int          mmax[2] = '{63, 3};
   int          bnd[17] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4097, 4096,
                            -1048576, 1048574, 1048575, 1048576, -1048578, 0, 1, -1};

   always #5 clk = ~clk;

   imem_program_encoder u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
      .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_f3), .in_funct7b5(in_f7), .in_imm(in_imm), .imem_we(we0),
      .imem_addr(addr0), .imem_wdata(wd0), .busy(busy0), .done(done0), .err(err0),
      .cpu_rst_n(crst0)
   );
   imem_program_encoder #(.ADDR_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
      .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_f3), .in_funct7b5(in_f7), .in_imm(in_imm), .imem_we(we1),
      .imem_addr(addr1), .imem_wdata(wd1), .busy(busy1), .done(done1), .err(err1),
      .cpu_rst_n(crst1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding built bit-field by bit-field with plain arithmetic.
   function automatic logic [31:0] ref_word(input int op, input int unsigned rd, rs1, rs2, f3, f7,
                                            input logic [31:0] imm);
      int unsigned u;
      u = imm;
      case (op)
         0: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
         1: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
                   ((u & 32'h1F) << 7) | 32'h23;
         2: return (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) |
                   (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
         4: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                   (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_legal(input int op, input int s);
      case (op)
         0, 1, 4: return s >= -2048 && s <= 2047;
         2:       return 1;
         3:       return s >= -4096 && s <= 4094 && s % 2 == 0;
         5:       return s >= -1048576 && s <= 1048574 && s % 2 == 0;
         default: return 0;
      endcase
   endfunction

   // Model states: 0 idle, 1 loading, 2 loaded, 3 aborted
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            mst[k] = 0; mptr[k] = 0; mwe[k] = 0;
         end else begin
            mwe[k] = 0;
            if (start) begin
               mst[k] = 1; mptr[k] = 0;
            end else if (mst[k] == 1 && in_valid) begin
               if (!ref_legal(32'(in_op), $signed(in_imm))) mst[k] = 3;
               else begin
                  mwe[k] = 1;
                  maddr[k] = mptr[k];
                  mwd[k] = ref_word(32'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                                    32'(in_f3), 32'(in_f7), in_imm);
                  if (in_last) mst[k] = 2;
                  else if (mptr[k] == mmax[k]) mst[k] = 3;
                  else mptr[k]++;
               end
            end
         end
      end
   end

   task automatic check_inst(input int k, input logic r, b, d, e, c, w,
                             input logic [31:0] a, input logic [31:0] wd);
      chk($sformatf("in_ready[%0d]", k), 32'(r), 32'(mst[k] == 1));
      chk($sformatf("busy[%0d]", k), 32'(b), 32'(mst[k] == 1));
      chk($sformatf("done[%0d]", k), 32'(d), 32'(mst[k] == 2));
      chk($sformatf("err[%0d]", k), 32'(e), 32'(mst[k] == 3));
      chk($sformatf("cpu_rst_n[%0d]", k), 32'(c), 32'(mst[k] == 2));
      chk($sformatf("imem_we[%0d]", k), 32'(w), 32'(mwe[k]));
      if (mwe[k]) begin
         chk($sformatf("imem_addr[%0d]", k), a, 32'(maddr[k]));
         chk($sformatf("imem_wdata[%0d]", k), wd, mwd[k]);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_inst(0, rdy0, busy0, done0, err0, crst0, we0, 32'(addr0), wd0);
         check_inst(1, rdy1, busy1, done1, err1, crst1, we1, 32'(addr1), wd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [2:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic f7, input logic [31:0] imm, input bit last);
      in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_f3 = f3; in_f7 = f7; in_imm = imm; in_last = last;
   endtask

   task automatic pulse_start();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, " we"}, 32'(we0), 0);
      chk({tag, " addr"}, 32'(addr0), 0);
      chk({tag, " wdata"}, wd0, 0);
      chk({tag, " busy"}, 32'(busy0), 0);
      chk({tag, " done"}, 32'(done0), 0);
      chk({tag, " err"}, 32'(err0), 0);
      chk({tag, " ready"}, 32'(rdy0), 0);
      chk({tag, " cpu_rst_n"}, 32'(crst0), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int s;
      bit v;
      rst_n = 0;
      repeat (2) tick();
      chk_zero0("reset");
      chk("reset small we", 32'(we1), 0);
      chk("reset small ready", 32'(rdy1), 0);
      rst_n = 1;
      tick();
      // lw then sw (last), back to back
      pulse_start();
      chk("ready after start", 32'(rdy0), 1);
      drive(1, 0, 5, 1, 0, 0, 0, 8, 0); tick();
      chk("lw we", 32'(we0), 1);
      chk("lw addr", 32'(addr0), 0);
      chk("lw word", wd0, 32'h0080A283);
      drive(1, 1, 0, 2, 5, 0, 0, 12, 1); tick();
      chk("sw we", 32'(we0), 1);
      chk("sw addr", 32'(addr0), 1);
      chk("sw word", wd0, 32'h00512623);
      chk("done after last", 32'(done0), 1);
      chk("cpu_rst_n after last", 32'(crst0), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("done no write", 32'(we0), 0);
      chk("done not ready", 32'(rdy0), 0);
      // R-type, beq, jal
      pulse_start();
      drive(1, 2, 3, 1, 2, 0, 1, 0, 0); tick();
      chk("rtype word", wd0, 32'h402081B3);
      drive(1, 3, 0, 1, 2, 0, 0, -4, 0); tick();
      chk("beq word", wd0, 32'hFE208EE3);
      drive(1, 5, 1, 0, 0, 0, 0, 8, 1); tick();
      chk("jal word", wd0, 32'h008000EF);
      chk("jal addr", 32'(addr0), 2);
      // illegal op, then odd branch offset
      pulse_start();
      drive(1, 6, 1, 1, 1, 0, 0, 0, 0); tick();
      chk("illegal op no write", 32'(we0), 0);
      chk("illegal op err", 32'(err0), 1);
      chk("illegal op cpu_rst_n", 32'(crst0), 0);
      chk("illegal op ready", 32'(rdy0), 0);
      tick();
      chk("err still not ready", 32'(rdy0), 0);
      pulse_start();
      chk("start clears err", 32'(err0), 0);
      drive(1, 3, 0, 1, 2, 0, 0, 3, 0); tick();
      chk("odd beq no write", 32'(we0), 0);
      chk("odd beq err", 32'(err0), 1);
      // overflow on the 4-word instance
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 5'(i), 1, 0, 0, 0, 32'(4 * i), 0); tick();
         if (i < 4) begin
            chk("ovf we", 32'(we1), 1);
            chk("ovf addr", 32'(addr1), 32'(i));
         end else begin
            chk("ovf fifth no write", 32'(we1), 0);
         end
         if (i >= 3) begin
            chk("ovf err", 32'(err1), 1);
            chk("ovf not ready", 32'(rdy1), 0);
         end
      end
      // reset mid-load
      pulse_start();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 0;
      #1 chk_zero0("mid reset");
      tick();
      rst_n = 1;
      tick();
      pulse_start();
      drive(1, 0, 7, 2, 0, 0, 0, 16, 0); tick();
      chk("reload we", 32'(we0), 1);
      chk("reload addr", 32'(addr0), 0);
      // gaps in in_valid
      pulse_start();
      a = 0;
      foreach (bnd[i]) begin
         v = (i % 3) != 1;
         if (i > 8) break;
         drive(v, 4, 5'(i), 3, 0, 3'(i), 0, 32'(i), 0); tick();
         chk("gap we", 32'(we0), 32'(v));
         if (v) begin
            chk("gap addr", 32'(addr0), 32'(a));
            a++;
         end
      end
      // randomized programs
      for (int p = 0; p < 60; p++) begin
         pulse_start();
         for (int c = 0; c < 40; c++) begin
            case ($urandom_range(0, 3))
               0: s = int'($urandom_range(0, 4095)) - 2048;
               1: s = bnd[$urandom_range(0, 16)];
               2: s = int'($urandom);
               default: s = int'($urandom_range(0, 2097151)) - 1048576;
            endcase
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'(s),
                  $urandom_range(0, 11) == 0);
            tick();
            if ($urandom_range(0, 149) == 0) begin
               #2 rst_n = 0;
               tick();
               rst_n = 1;
            end
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
